// File: rtl/ssp_uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// ssp_uart_arb_pkg
// Shared definitions for the SSP_UART register-port arbiter:
//   - FSM state encoding
//   - SSP_UART register address constants
//   - the power-up configuration table replayed after reset
// ---------------------------------------------------------------------------
package ssp_uart_arb_pkg;

   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_IDLE    = 2'd1,
      ST_ACCESS  = 2'd2,
      ST_CAPTURE = 2'd3
   } state_t;

   // SSP_UART register map
   localparam logic [2:0] RA_UCR0    = 3'd0;
   localparam logic [2:0] RA_UCR1    = 3'd1;
   localparam logic [2:0] RA_UCR2    = 3'd2;
   localparam logic [2:0] RA_RX_DATA = 3'd3;

   // Configuration table. The arbiter replays the first pInitCount entries,
   // so pInitCount must not exceed INIT_LEN.
   localparam int INIT_LEN = 3;
   localparam logic [2:0]  INIT_RA [INIT_LEN] = '{RA_UCR1, RA_UCR2, RA_UCR0};
   localparam logic [11:0] INIT_DI [INIT_LEN] = '{12'h0C1, 12'h001, 12'h000};

   // Returns {RA, DI} for table entry k; out-of-range entries read as zero.
   function automatic logic [14:0] init_entry(input int k);
      logic [14:0] entry;
      entry = '0;
      if (k >= 0 && k < INIT_LEN) entry = {INIT_RA[k], INIT_DI[k]};
      return entry;
   endfunction

endpackage

// File: rtl/ssp_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ssp_rr_arbiter
// Two-way grant with a last-served pointer.
//   clk, srst   : clock, synchronous active-high reset
//   req[1:0]    : request vector {req1, req0}
//   update      : load served_id into the last-served pointer
//   served_id   : requester just completed
//   grant_valid : at least one request present
//   grant_id    : winning requester (0 or 1)
// With fair_rr = 0 requester 0 always wins on contention.
// ---------------------------------------------------------------------------
module ssp_rr_arbiter #(
   parameter bit fair_rr = 1'b1
) (
   input  logic       clk,
   input  logic       srst,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       served_id,
   output logic       grant_valid,
   output logic       grant_id
);

   // Reset to 1 so requester 0 wins the first contention.
   logic last_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         last_reg <= 1'b1;
      end else if (update) begin
         last_reg <= served_id;
      end
   end

   always_comb begin
      grant_valid = |req;
      grant_id    = 1'b0;
      if (req == 2'b10) begin
         grant_id = 1'b1;
      end else if (req == 2'b11 && fair_rr) begin
         grant_id = ~last_reg;
      end
   end

endmodule

// File: rtl/ssp_uart_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ssp_uart_bus_arbiter
// Shares the SSP register port of SSP_UART between two requesters. After
// reset the configuration table is written into the UART, then requesters
// are served one access at a time (IDLE -> ACCESS -> CAPTURE -> IDLE).
// Ports:
//   iClk, iRst                 : clock (also the UART's SSP_SCK), sync reset
//   iReq/iWnR/iAddr/iWData 0/1 : requester transaction, held until oAck
//   oAck0/1, oRData0/1         : completion pulse and registered read data
//   oInitDone, oBusy           : init table written, FSM not idle
//   SSP_*                      : registered UART register-port strobes/data
// ---------------------------------------------------------------------------
module ssp_uart_bus_arbiter
   import ssp_uart_arb_pkg::*;
#(
   parameter int         pInitCount  = 3,
   parameter logic [2:0] pRxDataAddr = 3'd3,
   parameter bit         pFairRR     = 1'b1
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iReq0,
   input  logic        iWnR0,
   input  logic [2:0]  iAddr0,
   input  logic [11:0] iWData0,
   output logic        oAck0,
   output logic [11:0] oRData0,
   input  logic        iReq1,
   input  logic        iWnR1,
   input  logic [2:0]  iAddr1,
   input  logic [11:0] iWData1,
   output logic        oAck1,
   output logic [11:0] oRData1,
   output logic        oInitDone,
   output logic        oBusy,
   output logic        SSP_SSEL,
   output logic        SSP_EOC,
   output logic        SSP_WnR,
   output logic        SSP_En,
   output logic [2:0]  SSP_RA,
   output logic [11:0] SSP_DI,
   input  logic [11:0] SSP_DO
);

   state_t      state_reg, state_next;
   logic [3:0]  k_reg, k_next;
   logic        phase_reg, phase_next;      // 0: issue table write, 1: gap
   logic        init_done_reg, init_done_next;
   logic        busy_reg;
   logic        gnt_reg, gnt_next;
   logic        wnr_lat_reg, wnr_lat_next;
   logic        ssel_reg, ssel_next;
   logic        eoc_reg, eoc_next;
   logic        wnr_reg, wnr_next;
   logic        en_reg, en_next;
   logic [2:0]  ra_reg, ra_next;
   logic [11:0] di_reg, di_next;
   logic        ack0_reg, ack0_next;
   logic        ack1_reg, ack1_next;
   logic [11:0] rdata0_reg, rdata0_next;
   logic [11:0] rdata1_reg, rdata1_next;

   logic        grant_valid, grant_id, rr_update;
   logic        sel_wnr;
   logic [2:0]  sel_addr;
   logic [11:0] sel_wdata;

   ssp_rr_arbiter #(.fair_rr(pFairRR)) u_rr (
      .clk         (iClk),
      .srst        (iRst),
      .req         ({iReq1, iReq0}),
      .update      (rr_update),
      .served_id   (gnt_reg),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   assign sel_wnr   = grant_id ? iWnR1   : iWnR0;
   assign sel_addr  = grant_id ? iAddr1  : iAddr0;
   assign sel_wdata = grant_id ? iWData1 : iWData0;

   // The bus registers are loaded with the values for the state being
   // entered, so SSP_* is asserted exactly during the ACCESS cycle.
   always_comb begin
      state_next     = state_reg;
      k_next         = k_reg;
      phase_next     = phase_reg;
      init_done_next = init_done_reg;
      gnt_next       = gnt_reg;
      wnr_lat_next   = wnr_lat_reg;
      ssel_next      = 1'b0;
      eoc_next       = 1'b0;
      wnr_next       = 1'b0;
      en_next        = 1'b0;
      ra_next        = '0;
      di_next        = '0;
      ack0_next      = 1'b0;
      ack1_next      = 1'b0;
      rdata0_next    = rdata0_reg;
      rdata1_next    = rdata1_reg;
      rr_update      = 1'b0;

      case (state_reg)
         ST_INIT: begin
            if (pInitCount == 0) begin
               state_next     = ST_IDLE;
               init_done_next = 1'b1;
            end else if (!phase_reg) begin
               {ra_next, di_next} = init_entry(int'(k_reg));
               ssel_next  = 1'b1;
               eoc_next   = 1'b1;
               wnr_next   = 1'b1;
               phase_next = 1'b1;
            end else begin
               // Gap cycle after each table write.
               phase_next = 1'b0;
               if (int'(k_reg) == pInitCount - 1) begin
                  k_next         = '0;
                  state_next     = ST_IDLE;
                  init_done_next = 1'b1;
               end else begin
                  k_next = k_reg + 4'd1;
               end
            end
         end
         ST_IDLE: begin
            if (grant_valid) begin
               gnt_next     = grant_id;
               wnr_lat_next = sel_wnr;
               ssel_next    = 1'b1;
               eoc_next     = 1'b1;
               wnr_next     = sel_wnr;
               ra_next      = sel_addr;
               di_next      = sel_wnr ? sel_wdata : 12'd0;
               en_next      = !sel_wnr && (sel_addr == pRxDataAddr);
               state_next   = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // SSP_DO is valid during ACCESS; capture it with the ack so
            // oRData is already valid in the ack cycle.
            state_next = ST_CAPTURE;
            if (gnt_reg) begin
               ack1_next = 1'b1;
               if (!wnr_lat_reg) rdata1_next = SSP_DO;
            end else begin
               ack0_next = 1'b1;
               if (!wnr_lat_reg) rdata0_next = SSP_DO;
            end
         end
         ST_CAPTURE: begin
            rr_update  = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_reg     <= ST_INIT;
         k_reg         <= '0;
         phase_reg     <= 1'b0;
         init_done_reg <= 1'b0;
         busy_reg      <= 1'b0;
         gnt_reg       <= 1'b0;
         wnr_lat_reg   <= 1'b0;
         ssel_reg      <= 1'b0;
         eoc_reg       <= 1'b0;
         wnr_reg       <= 1'b0;
         en_reg        <= 1'b0;
         ra_reg        <= '0;
         di_reg        <= '0;
         ack0_reg      <= 1'b0;
         ack1_reg      <= 1'b0;
         rdata0_reg    <= '0;
         rdata1_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         k_reg         <= k_next;
         phase_reg     <= phase_next;
         init_done_reg <= init_done_next;
         busy_reg      <= (state_next != ST_IDLE);
         gnt_reg       <= gnt_next;
         wnr_lat_reg   <= wnr_lat_next;
         ssel_reg      <= ssel_next;
         eoc_reg       <= eoc_next;
         wnr_reg       <= wnr_next;
         en_reg        <= en_next;
         ra_reg        <= ra_next;
         di_reg        <= di_next;
         ack0_reg      <= ack0_next;
         ack1_reg      <= ack1_next;
         rdata0_reg    <= rdata0_next;
         rdata1_reg    <= rdata1_next;
      end
   end

   assign oAck0     = ack0_reg;
   assign oAck1     = ack1_reg;
   assign oRData0   = rdata0_reg;
   assign oRData1   = rdata1_reg;
   assign oInitDone = init_done_reg;
   assign oBusy     = busy_reg;
   assign SSP_SSEL  = ssel_reg;
   assign SSP_EOC   = eoc_reg;
   assign SSP_WnR   = wnr_reg;
   assign SSP_En    = en_reg;
   assign SSP_RA    = ra_reg;
   assign SSP_DI    = di_reg;

endmodule

// File: tb/tb_ssp_uart_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ssp_uart_bus_arbiter
// Directed bench for ssp_uart_bus_arbiter. Expected bus accesses and acks
// are queued when stimulus is driven and compared when the DUT produces
// them. A second instance (no init table, fixed priority) runs alongside.
// ---------------------------------------------------------------------------
module tb_ssp_uart_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, wnr0, req1, wnr1;
   logic [2:0]  addr0, addr1;
   logic [11:0] wdata0, wdata1, sdo;
   logic        ack0, ack1, init_done, busy;
   logic [11:0] rdata0, rdata1;
   logic        ssel, eoc, wnr, en;
   logic [2:0]  ra;
   logic [11:0] di;

   logic        b_req0, b_req1;
   logic        b_ack0, b_ack1, b_init_done, b_busy;
   logic [11:0] b_rdata0, b_rdata1;
   logic        b_ssel, b_eoc, b_wnr, b_en;
   logic [2:0]  b_ra;
   logic [11:0] b_di;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  ra;
      logic [11:0] di;
      logic        wnr;
      logic        en;
   } bus_t;

   typedef struct {
      logic        id;
      logic [11:0] rdata;
   } ack_t;

   bus_t        bus_q [$];
   ack_t        ack_q [$];
   logic [11:0] model_rd [2];

   always #5 clk = ~clk;

   ssp_uart_bus_arbiter #(.pInitCount(3), .pRxDataAddr(3'd3), .pFairRR(1'b1)) dut (
      .iClk(clk), .iRst(rst),
      .iReq0(req0), .iWnR0(wnr0), .iAddr0(addr0), .iWData0(wdata0),
      .oAck0(ack0), .oRData0(rdata0),
      .iReq1(req1), .iWnR1(wnr1), .iAddr1(addr1), .iWData1(wdata1),
      .oAck1(ack1), .oRData1(rdata1),
      .oInitDone(init_done), .oBusy(busy),
      .SSP_SSEL(ssel), .SSP_EOC(eoc), .SSP_WnR(wnr), .SSP_En(en),
      .SSP_RA(ra), .SSP_DI(di), .SSP_DO(sdo)
   );

   ssp_uart_bus_arbiter #(.pInitCount(0), .pRxDataAddr(3'd3), .pFairRR(1'b0)) dut_fp (
      .iClk(clk), .iRst(rst),
      .iReq0(b_req0), .iWnR0(1'b1), .iAddr0(3'd1), .iWData0(12'h0AA),
      .oAck0(b_ack0), .oRData0(b_rdata0),
      .iReq1(b_req1), .iWnR1(1'b1), .iAddr1(3'd2), .iWData1(12'h0BB),
      .oAck1(b_ack1), .oRData1(b_rdata1),
      .oInitDone(b_init_done), .oBusy(b_busy),
      .SSP_SSEL(b_ssel), .SSP_EOC(b_eoc), .SSP_WnR(b_wnr), .SSP_En(b_en),
      .SSP_RA(b_ra), .SSP_DI(b_di), .SSP_DO(sdo)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_init();
      bus_q.push_back('{3'd1, 12'h0C1, 1'b1, 1'b0});
      bus_q.push_back('{3'd2, 12'h001, 1'b1, 1'b0});
      bus_q.push_back('{3'd0, 12'h000, 1'b1, 1'b0});
   endtask

   // Queue the expected bus access and ack for one transaction (sdo must
   // already hold the value the UART returns for reads).
   task automatic push_txn(input logic id, input logic w, input logic [2:0] a,
                           input logic [11:0] d);
      bus_q.push_back('{a, (w ? d : 12'h000), w, (!w && a == 3'd3)});
      if (!w) model_rd[id] = sdo;
      ack_q.push_back('{id, model_rd[id]});
   endtask

   // Six cycles after reset release: writes in cycles 1,3,5, done in 6.
   task automatic check_init();
      for (int c = 1; c <= 6; c++) begin
         tick();
         $display("init cycle %0d: eoc=%b ra=%0d di=%h done=%b", c, eoc, ra, di, init_done);
         chk("init_eoc", eoc, (c % 2 == 1));
         chk("init_done", init_done, (c == 6));
         chk("init_no_ack", {ack0, ack1}, 2'b00);
         if (c == 1) chk("fp_init_done", b_init_done, 1'b1);
      end
   endtask

   // Monitor: every EOC strobe and every ack is matched against the queues.
   always @(negedge clk) begin
      bus_t e;
      ack_t a;
      if (eoc === 1'b1) begin
         chk("bus_expected", (bus_q.size() > 0), 1'b1);
         if (bus_q.size() > 0) begin
            e = bus_q.pop_front();
            $display("bus access: ra=%0d di=%h wnr=%b en=%b", ra, di, wnr, en);
            chk("bus_fields", {ssel, ra, di, wnr, en}, {1'b1, e.ra, e.di, e.wnr, e.en});
         end
      end
      if ((ack0 | ack1) === 1'b1) begin
         chk("ack_expected", (ack_q.size() > 0), 1'b1);
         if (ack_q.size() > 0) begin
            a = ack_q.pop_front();
            $display("ack: id=%0d rdata0=%h rdata1=%h", a.id, rdata0, rdata1);
            chk("ack_id", {ack1, ack0}, (a.id ? 2'b10 : 2'b01));
            chk("ack_rdata", (a.id ? rdata1 : rdata0), a.rdata);
            chk("other_rdata", (a.id ? rdata0 : rdata1), model_rd[!a.id]);
         end
      end
   end

   initial begin
      rst = 1'b1; sdo = '0;
      req0 = 0; wnr0 = 0; addr0 = '0; wdata0 = '0;
      req1 = 0; wnr1 = 0; addr1 = '0; wdata1 = '0;
      b_req0 = 0; b_req1 = 0;
      model_rd[0] = '0; model_rd[1] = '0;

      repeat (3) tick();
      chk("rst_bus", {ssel, eoc, wnr, en, ra, di}, '0);
      chk("rst_flags", {ack0, ack1, busy, init_done}, 4'b0000);
      chk("rst_rdata", {rdata0, rdata1}, '0);

      // Release reset with req1 already requesting a write.
      rst = 1'b0;
      req1 = 1; wnr1 = 1; addr1 = 3'd5; wdata1 = 12'h5A5;
      push_init();
      push_txn(1'b1, 1'b1, 3'd5, 12'h5A5);
      check_init();
      tick();
      chk("held_req_access", {eoc, wnr, ra, busy}, {1'b1, 1'b1, 3'd5, 1'b1});
      tick();
      chk("held_req_ack", ack1, 1'b1);
      req1 = 0;
      tick();

      // Single read from the RX data register.
      sdo = 12'h0A5;
      req0 = 1; wnr0 = 0; addr0 = 3'd3;
      push_txn(1'b0, 1'b0, 3'd3, 12'h000);
      tick();
      chk("rd_access", {eoc, en, wnr}, 3'b110);
      tick();
      chk("rd_ack", ack0, 1'b1);
      chk("rd_data", rdata0, 12'h0A5);
      req0 = 0;
      tick();
      chk("idle_busy", busy, 1'b0);

      // Write by req0 must not disturb oRData0.
      req0 = 1; wnr0 = 1; addr0 = 3'd4; wdata0 = 12'h123;
      push_txn(1'b0, 1'b1, 3'd4, 12'h123);
      tick();
      tick();
      chk("wr_ack", ack0, 1'b1);
      chk("wr_keeps_rdata", rdata0, 12'h0A5);
      req0 = 0;
      tick();

      // Read by req1 from a non-RX register: no pop enable.
      sdo = 12'h03C;
      req1 = 1; wnr1 = 0; addr1 = 3'd2;
      push_txn(1'b1, 1'b0, 3'd2, 12'h000);
      tick();
      chk("rd1_access", {eoc, en}, 2'b10);
      tick();
      chk("rd1_data", {ack1, rdata1}, {1'b1, 12'h03C});
      req1 = 0;
      tick();

      // Contention: round-robin on dut, fixed priority on dut_fp.
      req0 = 1; wnr0 = 1; addr0 = 3'd1; wdata0 = 12'h111;
      req1 = 1; wnr1 = 1; addr1 = 3'd2; wdata1 = 12'h222;
      b_req0 = 1; b_req1 = 1;
      push_txn(1'b0, 1'b1, 3'd1, 12'h111);
      push_txn(1'b1, 1'b1, 3'd2, 12'h222);
      push_txn(1'b0, 1'b1, 3'd1, 12'h111);
      push_txn(1'b1, 1'b1, 3'd2, 12'h222);
      for (int c = 1; c <= 12; c++) begin
         tick();
         chk("rr_ack0", ack0, (c == 2 || c == 8));
         chk("rr_ack1", ack1, (c == 5 || c == 11));
         chk("fp_ack0", b_ack0, (c == 2 || c == 5 || c == 8 || c == 11));
         chk("fp_ack1", b_ack1, 1'b0);
         if (c == 11) begin
            req0 = 0; req1 = 0; b_req0 = 0; b_req1 = 0;
         end
      end

      // Reset during ACCESS of a read.
      sdo = 12'h777;
      req0 = 1; wnr0 = 0; addr0 = 3'd3;
      push_txn(1'b0, 1'b0, 3'd3, 12'h000);
      tick();
      chk("mid_access", eoc, 1'b1);
      rst = 1'b1;
      tick();
      chk("mid_rst_bus", {ssel, eoc, wnr, en, ra, di}, '0);
      chk("mid_rst_flags", {ack0, ack1, init_done}, 3'b000);
      chk("mid_rst_rdata", rdata0, 12'h000);
      ack_q.delete();
      model_rd[0] = '0; model_rd[1] = '0;
      req0 = 0;
      rst = 1'b0;
      push_init();
      check_init();
      tick();

      chk("bus_q_empty", bus_q.size(), 0);
      chk("ack_q_empty", ack_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
